// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package debouncer_pkg;

  // Per-channel debounce FSM encoding.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions for counter widths.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, tick-counting FSM and edge pulses.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  ST_STABLE | synchronised input agrees with level; nothing pending
//  ST_WAIT   | input disagrees with level; counting ticks until accepted
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = 3,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change_next
);

  localparam int            CW   = clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync;
  logic          s;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, rise_nxt, fall_nxt;

  assign s           = sync[1];
  assign change_next = rise_nxt | fall_nxt;

  // Two-stage synchroniser for the asynchronous board input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= {2{RESET_LEVEL}};
    else       sync <= {sync[0], raw};
  end

  // FSM, tick counter, debounced level and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Next-state logic; an abort (input back to level) takes priority over a tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ST_STABLE: begin
        if (s != level) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (s == level) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt == LAST) begin
            level_nxt = ~level;
            rise_nxt  = ~level;
            fall_nxt  = level;
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/debouncer_multi.sv
// N-channel debouncer: shared tick source plus one debounce_channel per input.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 3,
  parameter bit EXT_TICK     = 1'b0,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic                tick_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  localparam int            PW         = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc;
  logic                presc_tick;
  logic                tick;
  logic [CHANNELS-1:0] change_next;

  assign presc_tick = (presc == PRESC_LAST);
  assign tick       = EXT_TICK ? tick_in : presc_tick;

  // Free-running prescaler; tick is high for the last count of each period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           presc <= '0;
    else if (presc_tick) presc <= '0;
    else                 presc <= presc + PW'(1);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .raw        (raw_in[g]),
      .tick       (tick),
      .level      (level[g]),
      .rise       (rise[g]),
      .fall       (fall[g]),
      .change_next(change_next[g])
    );
  end

  // Registered from the channels' next-pulse terms so it lines up with rise/fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_change <= 1'b0;
    else       any_change <= |change_next;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: an external-tick and an internal-tick instance,
// both compared every cycle against a behavioural model, plus directed checks.
module tb_debouncer_multi;

  localparam int TD = 4;
  localparam int ST = 3;

  logic       clk = 1'b0;
  logic       reset_e, reset_i;
  logic [1:0] raw_e, raw_i;
  logic       tick_e;
  logic       tick_unused = 1'b0;
  logic [1:0] level_e, rise_e, fall_e, level_i, rise_i, fall_i;
  logic       any_e, any_i;

  debouncer_multi #(.CHANNELS(2), .TICK_DIV(TD), .STABLE_TICKS(ST), .EXT_TICK(1'b1), .RESET_LEVEL(1'b0))
  dut_ext (.clk(clk), .reset(reset_e), .raw_in(raw_e), .tick_in(tick_e),
           .level(level_e), .rise(rise_e), .fall(fall_e), .any_change(any_e));

  debouncer_multi #(.CHANNELS(2), .TICK_DIV(TD), .STABLE_TICKS(ST), .EXT_TICK(1'b0), .RESET_LEVEL(1'b0))
  dut_int (.clk(clk), .reset(reset_i), .raw_in(raw_i), .tick_in(tick_unused),
           .level(level_i), .rise(rise_i), .fall(fall_i), .any_change(any_i));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int phase    = 0;
  bit rand_tick = 1'b0;

  // Model: level flips once ST ticks have been seen while the synchronised input
  // has disagreed continuously; the tick in the first disagreeing cycle is ignored.
  bit [1:0] m_lvl[2], m_rise[2], m_fall[2], m_sync1[2], m_s[2];
  bit       m_any[2];
  bit       m_div[2][2];
  int       m_nt[2][2];
  int       m_k;

  int rise_seen[2][2], fall_seen[2][2], any_seen[2], both_rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic       rst;
    logic [1:0] raw;
    logic       tk;
    for (int i = 0; i < 2; i++) begin
      rst = (i == 0) ? reset_e : reset_i;
      raw = (i == 0) ? raw_e : raw_i;
      tk  = (i == 0) ? tick_e : ((m_k % TD) == TD - 1);
      m_rise[i] = 2'b00;
      m_fall[i] = 2'b00;
      if (rst) begin
        m_lvl[i] = 2'b00; m_sync1[i] = 2'b00; m_s[i] = 2'b00;
        for (int c = 0; c < 2; c++) begin m_div[i][c] = 1'b0; m_nt[i][c] = 0; end
        if (i == 1) m_k = 0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (m_s[i][c] == m_lvl[i][c]) m_div[i][c] = 1'b0;
          else if (!m_div[i][c]) begin m_div[i][c] = 1'b1; m_nt[i][c] = 0; end
          else if (tk) begin
            m_nt[i][c]++;
            if (m_nt[i][c] == ST) begin
              if (m_lvl[i][c]) m_fall[i][c] = 1'b1; else m_rise[i][c] = 1'b1;
              m_lvl[i][c] = ~m_lvl[i][c];
              m_div[i][c] = 1'b0;
            end
          end
        end
        m_s[i] = m_sync1[i];
        m_sync1[i] = raw;
        if (i == 1) m_k++;
      end
      m_any[i] = |(m_rise[i] | m_fall[i]);
    end
  endtask

  task automatic check_outputs();
    check("ext_level", level_e, m_lvl[0]);
    check("ext_rise",  rise_e,  m_rise[0]);
    check("ext_fall",  fall_e,  m_fall[0]);
    check("ext_any",   any_e,   m_any[0]);
    check("int_level", level_i, m_lvl[1]);
    check("int_rise",  rise_i,  m_rise[1]);
    check("int_fall",  fall_i,  m_fall[1]);
    check("int_any",   any_i,   m_any[1]);
    for (int c = 0; c < 2; c++) begin
      rise_seen[0][c] += int'(rise_e[c]); fall_seen[0][c] += int'(fall_e[c]);
      rise_seen[1][c] += int'(rise_i[c]); fall_seen[1][c] += int'(fall_i[c]);
    end
    any_seen[0] += int'(any_e);
    any_seen[1] += int'(any_i);
    both_rise   += int'(rise_e == 2'b11);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 2; i++) begin
      any_seen[i] = 0;
      for (int c = 0; c < 2; c++) begin rise_seen[i][c] = 0; fall_seen[i][c] = 0; end
    end
    both_rise = 0;
  endtask

  // Called at a falling edge: drive the external tick, clock once, check.
  task automatic cycle();
    if (rand_tick) tick_e = ($urandom_range(3) == 0);
    else           tick_e = (phase == 3);
    @(posedge clk);
    model_edge();
    phase = (phase + 1) % 4;
    edge_n++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) cycle();
  endtask

  // Press on internal-tick channel 0; latency counted from the first cycle the
  // FSM sees the new synchronised level (two edges after raw is driven).
  task automatic measure_int_rise(input int start_edge, input string tag);
    int lat;
    lat = -1;
    for (int j = 0; j < 30 && lat < 0; j++) begin
      cycle();
      if (level_i[0]) lat = edge_n - (start_edge + 3);
    end
    check(tag, (lat >= (ST - 1) * TD && lat <= ST * TD), 1);
  endtask

  initial begin
    int n0;
    reset_e = 1'b1; reset_i = 1'b1;
    raw_e = 2'b11; raw_i = 2'b11; tick_e = 1'b0;
    @(negedge clk);
    run(3);
    check("rst_level", level_e, 2'b00);
    check("rst_rise",  rise_e,  2'b00);
    check("rst_fall",  fall_e,  2'b00);

    // Release: no pulse on the first cycle out of reset.
    raw_e = 2'b00; raw_i = 2'b00;
    reset_e = 1'b0; reset_i = 1'b0;
    clear_obs();
    cycle();
    check("rel_any", any_e, 1'b0);
    check("rel_rise", rise_e, 2'b00);
    run(4);

    // Glitch: high for two ticks only.
    while (phase != 1) cycle();
    clear_obs();
    raw_e = 2'b01;
    run(8);
    raw_e = 2'b00;
    run(16);
    check("glitch_level", level_e, 2'b00);
    check("glitch_pulses", rise_seen[0][0] + fall_seen[0][0], 0);

    // Clean press.
    clear_obs();
    raw_e = 2'b01;
    run(24);
    check("press_level", level_e, 2'b01);
    check("press_rise_once", rise_seen[0][0], 1);
    check("press_ch1_quiet", rise_seen[0][1], 0);

    // Release with a bounce back landing on a tick cycle (abort wins).
    while (phase != 1) cycle();
    clear_obs();
    raw_e = 2'b00;
    run(8);
    raw_e = 2'b01;
    run(16);
    check("bounce_no_fall", fall_seen[0][0], 0);
    check("bounce_level", level_e, 2'b01);
    raw_e = 2'b00;
    run(24);
    check("release_fall", fall_seen[0][0], 1);
    check("release_any", any_seen[0], 1);
    check("release_level", level_e, 2'b00);

    // Simultaneous press on both channels.
    clear_obs();
    raw_e = 2'b11;
    run(24);
    check("simul_rise11", both_rise, 1);
    check("simul_any_once", any_seen[0], 1);
    check("simul_level", level_e, 2'b11);

    // Internal tick latency at two prescaler phases.
    n0 = edge_n; raw_i = 2'b01;
    measure_int_rise(n0, "int_latency_a");
    raw_i = 2'b00; run(20);
    run(1 + $urandom_range(3));
    n0 = edge_n; raw_i = 2'b01;
    measure_int_rise(n0, "int_latency_b");
    raw_i = 2'b00; run(20);

    // Reset in the middle of a debounce discards the progress.
    raw_i = 2'b01;
    run(6);
    reset_i = 1'b1;
    #1;
    check("int_async_rst_level", level_i, 2'b00);
    @(negedge clk);
    run(2);
    n0 = edge_n; reset_i = 1'b0;
    measure_int_rise(n0, "int_latency_after_rst");

    // Random bouncing on both instances with random external ticks.
    rand_tick = 1'b1;
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(15) == 0) raw_e[0] = ~raw_e[0];
      if ($urandom_range(15) == 0) raw_e[1] = ~raw_e[1];
      if ($urandom_range(15) == 0) raw_i[0] = ~raw_i[0];
      if ($urandom_range(15) == 0) raw_i[1] = ~raw_i[1];
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
